// File: rtl/trap_reporter.sv
// trap_reporter: commit-side producer of the simulation halt report.
// Watches the commit stream for the halt instruction (or a no-commit
// watchdog expiry), waits for memory traffic to drain, then strobes exit for
// one cycle with the latched pc/a0/inst and parks in a halted state.
//
// Ports:
//   clock         sole clock
//   reset         asynchronous active-low reset
//   commit_valid  one instruction retires this cycle
//   commit_pc     pc of the retiring instruction
//   commit_inst   encoding of the retiring instruction
//   a0_value      architectural x10 including this cycle's writeback
//   drain_done    store buffer and bus idle
//   exit          single-cycle halt report strobe
//   pc/a0/inst    reported values, change only on a latch event
//   halted        level, high after the report (stall fetch)
//   retired       count of accepted commits
module trap_reporter #(
    parameter logic [31:0] TRAP_INST   = 32'h00100073,
    parameter int unsigned DRAIN_MAX   = 16,
    parameter int unsigned WDOG_CYCLES = 100000,
    parameter logic [63:0] WDOG_CODE   = 64'hDEAD
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        commit_valid,
    input  logic [63:0] commit_pc,
    input  logic [31:0] commit_inst,
    input  logic [63:0] a0_value,
    input  logic        drain_done,
    output logic        exit,
    output logic [63:0] pc,
    output logic [63:0] a0,
    output logic [31:0] inst,
    output logic        halted,
    output logic [63:0] retired
);

    localparam int unsigned DRAIN_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
    localparam int unsigned WDOG_W  = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        REPORT = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t              state, state_d;
    logic [DRAIN_W-1:0]  drain_cnt, drain_cnt_d;
    logic [WDOG_W-1:0]   wdog_cnt, wdog_cnt_d;
    logic [63:0]         retired_d, pc_d, a0_d;
    logic [31:0]         inst_d;
    logic                exit_d, halted_d;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d     = state;
        drain_cnt_d = drain_cnt;
        wdog_cnt_d  = wdog_cnt;
        retired_d   = retired;
        pc_d        = pc;
        a0_d        = a0;
        inst_d      = inst;

        unique case (state)
            IDLE: begin
                drain_cnt_d = '0;
                if (commit_valid) begin
                    // A commit always clears the watchdog, so a trap beats a
                    // watchdog expiry in the same cycle.
                    retired_d  = retired + 64'd1;
                    wdog_cnt_d = '0;
                    if (commit_inst == TRAP_INST) begin
                        pc_d    = commit_pc;
                        inst_d  = commit_inst;
                        a0_d    = a0_value;
                        state_d = DRAIN;
                    end
                end else if (WDOG_CYCLES != 0) begin
                    // This idle cycle is the WDOG_CYCLES-th in a row.
                    if (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1)) begin
                        pc_d       = '0;
                        inst_d     = '0;
                        a0_d       = WDOG_CODE;
                        wdog_cnt_d = '0;
                        state_d    = DRAIN;
                    end else begin
                        wdog_cnt_d = wdog_cnt + WDOG_W'(1);
                    end
                end
            end
            DRAIN: begin
                drain_cnt_d = drain_cnt + DRAIN_W'(1);
                if (drain_done || (drain_cnt == DRAIN_W'(DRAIN_MAX - 1))) begin
                    state_d = REPORT;
                end
            end
            REPORT: state_d = HALTED;
            HALTED: state_d = HALTED;
            default: state_d = IDLE;
        endcase

        exit_d   = (state_d == REPORT);
        halted_d = (state_d == HALTED);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            drain_cnt <= '0;
            wdog_cnt  <= '0;
            retired   <= '0;
            pc        <= '0;
            a0        <= '0;
            inst      <= '0;
            exit      <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state     <= state_d;
            drain_cnt <= drain_cnt_d;
            wdog_cnt  <= wdog_cnt_d;
            retired   <= retired_d;
            pc        <= pc_d;
            a0        <= a0_d;
            inst      <= inst_d;
            exit      <= exit_d;
            halted    <= halted_d;
        end
    end

endmodule

// File: tb/tb_trap_reporter.sv
// Self-checking bench for trap_reporter with a behavioural reference model.
module tb_trap_reporter;

    localparam logic [31:0] TRAP  = 32'h00100073;
    localparam logic [31:0] ECALL = 32'h00000073;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam int          DMAX  = 16;
    localparam int          WDOG  = 50;
    localparam logic [63:0] WCODE = 64'hDEAD;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        commit_valid = 1'b0;
    logic [63:0] commit_pc = '0;
    logic [31:0] commit_inst = '0;
    logic [63:0] a0_value = '0;
    logic        drain_done = 1'b0;
    logic        exit;
    logic [63:0] pc;
    logic [63:0] a0;
    logic [31:0] inst;
    logic        halted;
    logic [63:0] retired;

    int checks = 0;
    int failures = 0;

    trap_reporter #(
        .TRAP_INST  (TRAP),
        .DRAIN_MAX  (DMAX),
        .WDOG_CYCLES(WDOG),
        .WDOG_CODE  (WCODE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .commit_valid(commit_valid),
        .commit_pc   (commit_pc),
        .commit_inst (commit_inst),
        .a0_value    (a0_value),
        .drain_done  (drain_done),
        .exit        (exit),
        .pc          (pc),
        .a0          (a0),
        .inst        (inst),
        .halted      (halted),
        .retired     (retired)
    );

    always #5 clock = ~clock;

    // Reference model: phase 0 running, 1 waiting for drain, 2 reporting, 3 halted.
    int          m_phase, m_idle_run, m_waited;
    logic        m_exit, m_halted;
    logic [63:0] m_pc, m_a0, m_ret;
    logic [31:0] m_inst;

    task automatic model_reset();
        m_phase = 0; m_idle_run = 0; m_waited = 0;
        m_exit = 0; m_halted = 0; m_pc = '0; m_a0 = '0; m_ret = '0; m_inst = '0;
    endtask

    // Apply the rules for one clock edge using the inputs sampled at it.
    task automatic model_edge();
        if (!reset) begin
            model_reset();
        end else begin
            case (m_phase)
                0: begin
                    if (commit_valid) begin
                        m_ret = m_ret + 1;
                        m_idle_run = 0;
                        if (commit_inst == TRAP) begin
                            m_pc = commit_pc; m_inst = commit_inst; m_a0 = a0_value;
                            m_phase = 1; m_waited = 0;
                        end
                    end else begin
                        m_idle_run++;
                        if (m_idle_run == WDOG) begin
                            m_pc = '0; m_inst = '0; m_a0 = WCODE;
                            m_phase = 1; m_waited = 0;
                        end
                    end
                end
                1: begin
                    m_waited++;
                    if (drain_done || m_waited == DMAX) m_phase = 2;
                end
                2: m_phase = 3;
                default: m_phase = 3;
            endcase
            m_exit = (m_phase == 2);
            m_halted = (m_phase == 3);
        end
    endtask

    function automatic logic [225:0] dut_vec();
        return {exit, halted, pc, a0, inst, retired};
    endfunction

    function automatic logic [225:0] mdl_vec();
        return {m_exit, m_halted, m_pc, m_a0, m_inst, m_ret};
    endfunction

    // Drive one cycle of inputs, advance the clock and the model, settle past the edge.
    task automatic cycle(input logic cv, input logic [63:0] cpc, input logic [31:0] ci,
                         input logic [63:0] a0v, input logic dd);
        commit_valid = cv; commit_pc = cpc; commit_inst = ci; a0_value = a0v; drain_done = dd;
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle(0, '0, '0, '0, 0);
        cycle(0, '0, '0, '0, 0);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        model_reset();
        checks++;
        if (dut_vec() !== 226'd0) begin
            failures++;
            $display("FAIL reset_async got=%h exp=0", dut_vec());
        end
        cycle(0, '0, '0, '0, 0);
        checks++;
        if (dut_vec() !== mdl_vec()) begin
            failures++;
            $display("FAIL reset_held got=%h exp=%h", dut_vec(), mdl_vec());
        end
        reset = 1'b1;
    endtask

    task automatic test_good_trap();
        int first_exit = -1;
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1, 64'h80000000 + 64'(4 * i), NOP, 64'(i + 7), 1);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++;
                $display("FAIL good_trap_pre cyc=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
            end
        end
        cycle(1, 64'h80000010, TRAP, 64'd0, 1);
        for (int k = 1; k <= 4; k++) begin
            cycle(0, '0, '0, 64'h55, 1);
            if (exit) begin
                pulses++;
                if (first_exit < 0) first_exit = k;
            end
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++;
                $display("FAIL good_trap_post k=%0d got=%h exp=%h", k, dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (first_exit != 1 || pulses != 1) begin
            failures++;
            $display("FAIL good_trap_latency got edge=%0d pulses=%0d exp edge=1 pulses=1", first_exit, pulses);
        end
        checks++;
        if ({pc, a0, inst, retired, halted} !== {64'h80000010, 64'd0, TRAP, 64'd5, 1'b1}) begin
            failures++;
            $display("FAIL good_trap_final got pc=%h a0=%h inst=%h ret=%0d halted=%b",
                     pc, a0, inst, retired, halted);
        end
    endtask

    // Trap with a0=1 and drain_done held low for hold_cycles DRAIN cycles.
    task automatic test_bad_trap(input int hold_cycles, input int exp_edge);
        int first_exit = -1;
        do_reset();
        cycle(1, 64'h80000000, NOP, 64'd3, 0);
        cycle(1, 64'h80000004, TRAP, 64'd1, 0);
        for (int k = 1; k <= DMAX + 3; k++) begin
            cycle(0, '0, '0, 64'h9, (k > hold_cycles));
            if (exit && first_exit < 0) first_exit = k;
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++;
                $display("FAIL bad_trap hold=%0d k=%0d got=%h exp=%h", hold_cycles, k, dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (first_exit != exp_edge || a0 !== 64'd1) begin
            failures++;
            $display("FAIL bad_trap_latency hold=%0d got edge=%0d a0=%h exp edge=%0d a0=1",
                     hold_cycles, first_exit, a0, exp_edge);
        end
    endtask

    // No commits at all, or a trap landing on the last idle cycle before expiry.
    task automatic test_watchdog(input logic trap_at_limit);
        int first_exit = -1;
        do_reset();
        for (int k = 1; k <= WDOG + 4; k++) begin
            if (trap_at_limit && k == WDOG) cycle(1, 64'h80000100, TRAP, 64'h0, 1);
            else cycle(0, '0, '0, 64'h77, 1);
            if (exit && first_exit < 0) first_exit = k;
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++;
                $display("FAIL watchdog trap=%0b k=%0d got=%h exp=%h", trap_at_limit, k, dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (trap_at_limit) begin
            if (first_exit != WDOG + 1 || {pc, a0, retired} !== {64'h80000100, 64'd0, 64'd1}) begin
                failures++;
                $display("FAIL watchdog_trap_wins got edge=%0d pc=%h a0=%h ret=%0d", first_exit, pc, a0, retired);
            end
        end else begin
            if (first_exit != WDOG + 1 || {pc, a0, inst} !== {64'd0, WCODE, 32'd0}) begin
                failures++;
                $display("FAIL watchdog_fire got edge=%0d pc=%h a0=%h inst=%h exp edge=%0d a0=dead",
                         first_exit, pc, a0, inst, WDOG + 1);
            end
        end
    endtask

    task automatic test_post_trap_commits();
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1, 64'($urandom), NOP, 64'($urandom), $urandom_range(0, 1) == 1);
        cycle(1, 64'h80001234, TRAP, 64'h42, 0);
        for (int k = 0; k < 30; k++) begin
            cycle(1, 64'($urandom), (k % 3 == 0) ? TRAP : 32'($urandom), 64'($urandom), $urandom_range(0, 3) == 0);
            if (exit) pulses++;
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++;
                $display("FAIL post_trap k=%0d got=%h exp=%h", k, dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (pulses != 1 || retired !== 64'd7 || pc !== 64'h80001234 || a0 !== 64'h42) begin
            failures++;
            $display("FAIL post_trap_frozen got pulses=%0d ret=%0d pc=%h a0=%h", pulses, retired, pc, a0);
        end
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        cycle(1, 64'h80000000, NOP, 64'd0, 0);
        cycle(1, 64'h80000004, TRAP, 64'd5, 0);
        cycle(0, '0, '0, '0, 0);
        cycle(0, '0, '0, '0, 0);
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_vec() !== 226'd0) begin
            failures++;
            $display("FAIL reset_in_drain got=%h exp=0", dut_vec());
        end
        for (int k = 0; k < 3; k++) begin
            cycle(0, '0, '0, '0, 1);
            checks++;
            if (exit !== 1'b0 || dut_vec() !== 226'd0) begin
                failures++;
                $display("FAIL reset_in_drain_hold k=%0d got=%h exp=0", k, dut_vec());
            end
        end
        reset = 1'b1;
        cycle(1, 64'h80000020, TRAP, 64'd0, 1);
        cycle(0, '0, '0, '0, 1);
        checks++;
        if ({exit, pc, a0, retired} !== {1'b1, 64'h80000020, 64'd0, 64'd1}) begin
            failures++;
            $display("FAIL reset_then_trap got exit=%b pc=%h a0=%h ret=%0d", exit, pc, a0, retired);
        end
    endtask

    task automatic test_ecall();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1, 64'h80000000 + 64'(4 * i), ECALL, 64'd1, 1);
            cycle(0, '0, '0, '0, 1);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++;
                $display("FAIL ecall i=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (exit !== 1'b0 || halted !== 1'b0 || retired !== 64'd5) begin
            failures++;
            $display("FAIL ecall_final got exit=%b halted=%b ret=%0d exp 0 0 5", exit, halted, retired);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 149) == 0) reset = 1'b0;
            else reset = 1'b1;
            cycle($urandom_range(0, 9) < 6, 64'($urandom),
                  ($urandom_range(0, 24) == 0) ? TRAP : 32'($urandom),
                  64'($urandom_range(0, 2)), $urandom_range(0, 2) == 0);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++;
                $display("FAIL random k=%0d got=%h exp=%h", k, dut_vec(), mdl_vec());
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_good_trap();
        test_bad_trap(DMAX + 10, DMAX);
        test_bad_trap(3, 4);
        test_watchdog(1'b0);
        test_watchdog(1'b1);
        test_post_trap_commits();
        test_reset_in_drain();
        test_ecall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trap_reporter.md
Name: trap_reporter

Overview:
- Commit-side producer of the simulation halt interface (exit, pc, a0, inst) consumed by the simulation debug monitor.
- Watches the writeback/commit stream and detects the ebreak trap instruction.
- Waits for in-flight memory traffic to drain, then issues a single-cycle exit report with latched pc, a0 and inst.
- Also provides a no-commit watchdog that forces a bad-trap report, and a retired-instruction counter.

Parameters:
- TRAP_INST, 32'h00100073, instruction encoding that requests halt (ebreak).
- DRAIN_MAX, 16, maximum cycles to wait for drain_done before reporting anyway.
- WDOG_CYCLES, 100000, consecutive cycles without a commit that trigger a watchdog trap; 0 disables the watchdog.
- WDOG_CODE, 64'hDEAD, a0 value reported on a watchdog trap (nonzero, so the report is a bad trap).

Ports:
- clock  input  1  sole clock.
- reset  input  1  asynchronous, active-low reset.
- commit_valid  input  1  one instruction retires this cycle.
- commit_pc  input  64  pc of the retiring instruction.
- commit_inst  input  32  encoding of the retiring instruction.
- a0_value  input  64  current architectural x10, bypassed to include this cycle's writeback.
- drain_done  input  1  store buffer and bus idle.
- exit  output  1  single-cycle halt report strobe.
- pc  output  64  reported pc.
- a0  output  64  reported a0.
- inst  output  32  reported instruction.
- halted  output  1  level; high after the report, tells the core to stall fetch.
- retired  output  64  count of commits accepted.

Behaviour:
- Reset (async assert, sync release): state=IDLE, exit=0, halted=0, pc=0, a0=0, inst=0, retired=0, drain and watchdog counters=0.
- States: IDLE, DRAIN, REPORT, HALTED.
- IDLE:
  - Each commit_valid increments retired (wraps modulo 2^64) and clears the watchdog counter.
  - Cycles without a commit increment the watchdog counter.
  - commit_valid && commit_inst==TRAP_INST: latch pc=commit_pc, inst=commit_inst, a0=a0_value in the same edge; go to DRAIN. The trap commit itself counts in retired.
  - Watchdog reaches WDOG_CYCLES (and WDOG_CYCLES≠0) with no commit: latch pc=0, inst=0, a0=WDOG_CODE; go to DRAIN.
  - A trap commit in the same cycle the watchdog would expire: the trap wins, because the commit clears the watchdog.
- DRAIN:
  - The drain counter increments every cycle.
  - Go to REPORT when drain_done==1 or the counter reaches DRAIN_MAX-1, whichever comes first.
  - Minimum one cycle in DRAIN, even if drain_done is already high.
  - commit_valid in DRAIN or later is ignored: retired is not incremented and nothing is latched.
- REPORT: exit=1 for exactly one cycle; pc, a0 and inst are stable and equal to the latched values; go to HALTED.
- HALTED: exit=0; halted=1; pc, a0 and inst hold; terminal until reset.
- Latency: trap commit at edge N → exit high in cycle N+2 at the earliest (drain_done already high).
- Outputs pc, a0 and inst change only on a latch event and are otherwise stable.
- exit is registered, never combinational from inputs.
- Reset asserted mid-DRAIN or in HALTED: immediate return to reset values; no exit pulse is emitted.

Test Plan:
- Good trap: commits at pc 0x80000000..0x8000000C, then TRAP_INST at 0x80000010 with a0_value=0, drain_done=1 → exit pulses once 2 cycles later; pc=0x80000010, a0=0, inst=0x00100073, retired=5, halted=1 afterwards.
- Bad trap with drain stall: trap with a0_value=1, drain_done held 0 → exit asserts after DRAIN_MAX=16 cycles in DRAIN with a0=1; a second variant raising drain_done after 3 cycles → exit one cycle after that.
- Watchdog: WDOG_CYCLES=50, no commits after reset → exit asserts with a0=0xDEAD, pc=0; trap on cycle 49 → normal report instead.
- Post-trap commits: commit_valid pulses continue after the trap → retired frozen, latched values unchanged, exactly one exit pulse.
- Async reset while in DRAIN → all outputs 0 immediately, no exit; a subsequent trap reports correctly.
- Non-trap instruction 0x00000073 (ecall) → no report; retired increments.
